// File: rtl/snake_pkg.sv
// Shared encodings for the snake direction controller:
// directions, parser states and PS/2 scancodes.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_EXT,
    PS_BRK,
    PS_EXT_BRK
  } ps_state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  function automatic logic [1:0] rev_dir(
    input logic [1:0] d
  );
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/ps2_scan_decoder.sv
// PS/2 scancode parser: tracks E0/F0 prefixes and
// emits one-cycle direction and pause requests.
module ps2_scan_decoder
  import snake_pkg::*;
(
  input  logic       CLK,
  input  logic       rstn,
  input  logic       clr,
  input  logic [7:0] keycode,
  input  logic       newkeyStrobe,
  output logic       dir_req,
  output logic [1:0] dir_code,
  output logic       pause_req
);

  ps_state_t st;

  logic mk_hit;
  logic ex_hit;
  logic sp_hit;
  dir_t mk_dir;
  dir_t ex_dir;

  always_comb begin
    mk_hit = 1'b1;
    mk_dir = DIR_UP;
    unique case (1'b1)
      (keycode == SC_W): mk_dir = DIR_UP;
      (keycode == SC_S): mk_dir = DIR_DOWN;
      (keycode == SC_A): mk_dir = DIR_LEFT;
      (keycode == SC_D): mk_dir = DIR_RIGHT;
      default:           mk_hit = 1'b0;
    endcase
  end

  always_comb begin
    ex_hit = 1'b1;
    ex_dir = DIR_UP;
    unique case (1'b1)
      (keycode == SC_UP):    ex_dir = DIR_UP;
      (keycode == SC_DOWN):  ex_dir = DIR_DOWN;
      (keycode == SC_LEFT):  ex_dir = DIR_LEFT;
      (keycode == SC_RIGHT): ex_dir = DIR_RIGHT;
      default:               ex_hit = 1'b0;
    endcase
  end

  assign sp_hit = (keycode == SC_SPACE);

  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      st        <= PS_IDLE;
      dir_req   <= 1'b0;
      dir_code  <= DIR_UP;
      pause_req <= 1'b0;
    end else begin
      dir_req   <= 1'b0;
      pause_req <= 1'b0;
      if (clr) begin
        st <= PS_IDLE;
      end else if (newkeyStrobe) begin
        unique case (st)
          PS_IDLE: begin
            if (keycode == SC_EXT) begin
              st <= PS_EXT;
            end else if (keycode == SC_BRK) begin
              st <= PS_BRK;
            end else begin
              dir_req   <= mk_hit;
              dir_code  <= mk_dir;
              pause_req <= sp_hit;
            end
          end
          PS_EXT: begin
            if (keycode == SC_BRK) begin
              st <= PS_EXT_BRK;
            end else begin
              st       <= PS_IDLE;
              dir_req  <= ex_hit;
              dir_code <= ex_dir;
            end
          end
          // release byte after F0: swallowed
          default: st <= PS_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/snake_dir_controller.sv
// Snake direction controller: keyboard direction queue,
// tick-driven direction updates and pause handling.
module snake_dir_controller
  import snake_pkg::*;
#(
  parameter int unsigned QDEPTH   = 2,
  parameter logic [1:0]  INIT_DIR = 2'b11
) (
  input  logic       CLK,
  input  logic       rstn,
  input  logic [7:0] keycode,
  input  logic       newkeyStrobe,
  input  logic       game_tick,
  input  logic       game_over,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic       paused,
  output logic [2:0] q_count
);

  logic       dir_req;
  logic [1:0] dir_code;
  logic       pause_req;

  ps2_scan_decoder u_dec (
    .CLK          (CLK),
    .rstn         (rstn),
    .clr          (game_over),
    .keycode      (keycode),
    .newkeyStrobe (newkeyStrobe),
    .dir_req      (dir_req),
    .dir_code     (dir_code),
    .pause_req    (pause_req)
  );

  logic [1:0] q  [QDEPTH];
  logic [1:0] qn [QDEPTH];
  logic [2:0] cnt;
  logic [2:0] cnt_n;
  logic [1:0] refd;
  logic       full;
  logic       pop;
  logic       push;
  logic       tick_ok;

  // reference is the newest queued entry, else the live direction
  always_comb begin
    refd = dir;
    for (int i = 0; i < QDEPTH; i++) begin
      if (cnt == 3'(i + 1)) refd = q[i];
    end
  end

  assign full    = (cnt == 3'(QDEPTH));
  assign tick_ok = game_tick && !paused && !game_over;
  assign pop     = tick_ok && (cnt != 3'd0);
  assign push    = dir_req && !paused && !game_over &&
                   (dir_code != refd) &&
                   (dir_code != rev_dir(refd)) &&
                   (!full || pop);

  always_comb begin
    cnt_n = cnt;
    for (int i = 0; i < QDEPTH; i++) qn[i] = q[i];
    if (pop) begin
      for (int i = 0; i < QDEPTH - 1; i++) qn[i] = q[i + 1];
      qn[QDEPTH-1] = 2'b00;
      cnt_n = cnt - 3'd1;
    end
    if (push) begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (cnt_n == 3'(i)) qn[i] = dir_code;
      end
      cnt_n = cnt_n + 3'd1;
    end
  end

  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < QDEPTH; i++) q[i] <= 2'b00;
      cnt       <= 3'd0;
      dir       <= INIT_DIR;
      dir_valid <= 1'b0;
      paused    <= 1'b0;
    end else if (game_over) begin
      for (int i = 0; i < QDEPTH; i++) q[i] <= 2'b00;
      cnt       <= 3'd0;
      dir       <= INIT_DIR;
      dir_valid <= 1'b0;
      paused    <= 1'b0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) q[i] <= qn[i];
      cnt       <= cnt_n;
      dir_valid <= tick_ok;
      if (pop) dir <= q[0];
      if (pause_req) paused <= !paused;
    end
  end

  assign q_count = cnt;

endmodule

// File: tb/tb_snake_dir_controller.sv
// Scoreboard bench for snake_dir_controller: reference
// model predicts outputs each edge, monitor compares.
module tb_snake_dir_controller;

  localparam int QD = 2;
  localparam logic [1:0] INIT = 2'b11;

  logic       CLK;
  logic       rstn;
  logic [7:0] keycode;
  logic       newkeyStrobe;
  logic       game_tick;
  logic       game_over;
  logic [1:0] dir;
  logic       dir_valid;
  logic       paused;
  logic [2:0] q_count;

  snake_dir_controller #(
    .QDEPTH   (QD),
    .INIT_DIR (INIT)
  ) dut (
    .CLK          (CLK),
    .rstn         (rstn),
    .keycode      (keycode),
    .newkeyStrobe (newkeyStrobe),
    .game_tick    (game_tick),
    .game_over    (game_over),
    .dir          (dir),
    .dir_valid    (dir_valid),
    .paused       (paused),
    .q_count      (q_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int ncmp = 0;
  int nbad = 0;
  int nvalid = 0;

  logic [6:0] expq [$];

  // reference model state
  logic [1:0] mq [$];
  logic [1:0] mdir = INIT;
  bit         mpaused = 1'b0;
  bit         e0 = 1'b0;
  bit         f0 = 1'b0;
  int         pk = 0;
  logic [1:0] pd = 2'b00;
  bit         mv, popn, acc;
  logic [1:0] r, nd;
  int         kd;

  // spot-check request from stimulus to monitor
  string sname = "";
  int    ssel = 0;
  int    sexp = 0;
  int    sseq = 0;
  int    sdone = 0;

  function automatic int kdec(bit ext, logic [7:0] k);
    int res;
    res = -1;
    if (!ext) begin
      case (k)
        8'h1D: res = 0;
        8'h1B: res = 1;
        8'h1C: res = 2;
        8'h23: res = 3;
        8'h29: res = 4;
        default: res = -1;
      endcase
    end else begin
      case (k)
        8'h75: res = 0;
        8'h72: res = 1;
        8'h6B: res = 2;
        8'h74: res = 3;
        default: res = -1;
      endcase
    end
    return res;
  endfunction

  always @(posedge CLK) begin
    if (!rstn || game_over) begin
      mq.delete();
      mdir = INIT;
      mpaused = 1'b0;
      mv = 1'b0;
      e0 = 1'b0;
      f0 = 1'b0;
      pk = 0;
    end else begin
      mv = game_tick && !mpaused;
      popn = mv && (mq.size() > 0);
      nd = popn ? mq[0] : mdir;
      acc = 1'b0;
      if (pk == 1) begin
        r = (mq.size() > 0) ? mq[$] : mdir;
        acc = !mpaused && (pd != r) && (pd != (r ^ 2'b01)) &&
              ((mq.size() < QD) || popn);
      end
      if (popn) void'(mq.pop_front());
      if (acc) mq.push_back(pd);
      if (pk == 2) mpaused = !mpaused;
      mdir = nd;
      pk = 0;
      if (newkeyStrobe) begin
        if (f0) begin
          f0 = 1'b0;
          e0 = 1'b0;
        end else if (keycode == 8'hF0) begin
          f0 = 1'b1;
        end else if (keycode == 8'hE0 && !e0) begin
          e0 = 1'b1;
        end else begin
          kd = kdec(e0, keycode);
          e0 = 1'b0;
          if (kd == 4) pk = 2;
          else if (kd >= 0) begin
            pk = 1;
            pd = 2'(kd);
          end
        end
      end
    end
    expq.push_back({mv, mdir, mpaused, 3'(mq.size())});
  end

  always @(negedge CLK) begin
    logic [6:0] e;
    logic [6:0] a;
    int act;
    if (sseq != sdone) begin
      sdone = sseq;
      case (ssel)
        0: act = int'(dir);
        1: act = int'(q_count);
        2: act = int'(paused);
        default: act = nvalid;
      endcase
      ncmp++;
      if (act != sexp) begin
        nbad++;
        $display("FAIL %s: got %0d want %0d", sname, act, sexp);
      end
    end
    if (dir_valid === 1'b1) nvalid++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {dir_valid, dir, paused, q_count};
      ncmp++;
      if (a !== e) begin
        nbad++;
        $display("FAIL cycle @%0t: got v=%b dir=%b p=%b q=%0d want v=%b dir=%b p=%b q=%0d",
                 $time, a[6], a[5:4], a[3], a[2:0],
                 e[6], e[5:4], e[3], e[2:0]);
      end
    end
  end

  task automatic cyc(input bit s, input logic [7:0] k,
                     input bit t, input bit g);
    newkeyStrobe = s;
    keycode = k;
    game_tick = t;
    game_over = g;
    @(negedge CLK);
    #1;
  endtask

  task automatic key(input logic [7:0] k);
    cyc(1'b1, k, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic tick();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic spot(input string n, input int sel, input int ex);
    sname = n;
    ssel = sel;
    sexp = ex;
    sseq++;
    idle();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle();
    idle();
    rstn = 1'b1;
  endtask

  logic [7:0] keys [12] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23,
                            8'h29, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};

  initial begin
    int nv0;
    rstn = 1'b0;
    keycode = 8'h00;
    newkeyStrobe = 1'b0;
    game_tick = 1'b0;
    game_over = 1'b0;
    do_reset();
    spot("reset_dir", 0, 3);
    spot("reset_q", 1, 0);

    nv0 = nvalid;
    tick(); tick(); tick();
    spot("ticks_dir", 0, 3);
    spot("ticks_valid", 3, nv0 + 3);

    key(8'h1D); key(8'hF0); key(8'h1D); idle();
    tick();
    spot("release_dir", 0, 0);
    spot("release_q", 1, 0);

    do_reset();
    key(8'hE0); key(8'h6B); idle();
    spot("reversal_q", 1, 0);
    key(8'h1D); key(8'h1C); idle();
    spot("two_q", 1, 2);
    tick();
    spot("pop1_dir", 0, 0);
    tick();
    spot("pop2_dir", 0, 2);

    key(8'h1D); idle(); tick();
    key(8'h1C); key(8'h1D); idle();
    spot("full_q", 1, 2);
    key(8'h23); tick();
    spot("fullpush_q", 1, 2);
    spot("fullpush_dir", 0, 2);
    tick(); tick();
    spot("tail_right", 0, 3);

    key(8'h29); idle();
    spot("pause_on", 2, 1);
    nv0 = nvalid;
    tick(); tick(); tick(); tick();
    spot("pause_novalid", 3, nv0);
    key(8'h1B); idle();
    spot("pause_drop", 1, 0);
    key(8'h29); idle();
    spot("pause_off", 2, 0);
    nv0 = nvalid;
    tick();
    spot("resume_valid", 3, nv0 + 1);

    key(8'h1D); key(8'h1C); key(8'h29); idle();
    spot("pre_go_q", 1, 2);
    spot("pre_go_p", 2, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    spot("go_q", 1, 0);
    spot("go_dir", 0, 3);
    spot("go_p", 2, 0);

    key(8'hE0);
    rstn = 1'b0;
    idle();
    rstn = 1'b1;
    key(8'h75); idle();
    spot("midscan_q", 1, 0);
    spot("midscan_dir", 0, 3);

    for (int i = 0; i < 3000; i++) begin
      int ki;
      logic [7:0] kb;
      ki = int'($urandom_range(0, 11));
      kb = keys[ki];
      if (ki == 11) kb = 8'($urandom);
      rstn = ($urandom_range(0, 299) != 0);
      cyc(($urandom_range(0, 9) < 4), kb,
          ($urandom_range(0, 9) < 2),
          ($urandom_range(0, 99) == 0));
    end
    rstn = 1'b1;
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/snake_dir_controller.md
SNAKE_DIR_CONTROLLER -- requirements
Module: snake_dir_controller

Interface
REQ-001 Parameter QDEPTH, default 2, depth of the direction queue; legal values 2..4.
REQ-002 Parameter INIT_DIR, default 2'b11 (RIGHT), direction after reset or game over.
REQ-003 CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 keycode  input  8  PS/2 scancode byte from the keyboard receiver; valid only when newkeyStrobe=1.
REQ-006 newkeyStrobe  input  1  one-CLK pulse per received scancode byte.
REQ-007 game_tick  input  1  one-CLK pulse per snake move step.
REQ-008 game_over  input  1  level; high freezes and clears the controller.
REQ-009 dir  output  2  current snake direction: 00 UP, 01 DOWN, 10 LEFT, 11 RIGHT.
REQ-010 dir_valid  output  1  one-CLK pulse: move the snake one step in dir.
REQ-011 paused  output  1  pause state, toggled by the space key.
REQ-012 q_count  output  3  number of queued directions, 0..QDEPTH.

Function
REQ-013 The parser FSM SHALL have states IDLE, EXT (after E0), BRK (after F0) and EXT_BRK (after E0 then F0), and SHALL advance only on newkeyStrobe.
REQ-014 Parser transitions: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXT_BRK; BRK/EXT_BRK+any byte->IDLE, with the byte discarded as a release; IDLE/EXT+any other byte->IDLE, with the byte decoded as a make code.
REQ-015 Make codes in IDLE SHALL map 1D->UP, 1B->DOWN, 1C->LEFT, 23->RIGHT and 29->pause toggle; all other bytes SHALL be ignored.
REQ-016 Make codes in EXT SHALL map 75->UP, 72->DOWN, 6B->LEFT, 74->RIGHT; all other bytes SHALL be ignored.
REQ-017 The reference direction for a decoded direction SHALL be the queue tail if q_count>0, else dir.
REQ-018 A decoded direction SHALL be dropped if it equals the reference or is its reversal ({ref[1],~ref[0]}), if the queue is full with no pop in the same cycle, if paused=1, or if game_over=1.
REQ-019 Otherwise the direction SHALL be pushed, and q_count SHALL increment in the same edge.
REQ-020 On game_tick with paused=0 and game_over=0: if q_count>0, the head SHALL be popped into dir; dir_valid SHALL pulse in the same cycle dir updates, i.e. one CLK after game_tick.
REQ-021 On game_tick with paused=1 or game_over=1: no pop and no dir_valid pulse.
REQ-022 Simultaneous push and pop SHALL both occur; q_count SHALL be unchanged, and a full queue SHALL accept the push.
REQ-023 If a simultaneous push uses dir as its reference (q_count=0), dir is the pre-pop value.
REQ-024 The pause toggle SHALL take effect on the edge after its strobe; the queue SHALL be retained across a pause.
REQ-025 While game_over=1: queue flushed (q_count=0), dir=INIT_DIR, paused=0, parser held in IDLE, dir_valid=0.
REQ-026 Decoding latency: strobe at edge N -> queue and q_count updated at edge N+1.

Reset
REQ-027 rstn=0 SHALL asynchronously force parser=IDLE, dir=INIT_DIR, dir_valid=0, paused=0, q_count=0 and the queue contents to 0.
REQ-028 Deassertion mid-scancode SHALL leave the parser in IDLE, so a stray trailing byte is decoded as a fresh make code.

Structure
REQ-029 Direction encodings and the scancode constants (E0, F0, 1D, 1B, 1C, 23, 29, 75, 72, 6B, 74) SHALL live in the shared snake_pkg package or include file.
REQ-030 The parser SHALL be a sub-module, ps2_scan_decoder, emitting a one-CLK dir_req pulse with dir_code[1:0] and a pause_req pulse.
REQ-031 The queue, arbitration and pause logic SHALL reside in snake_dir_controller.

Verification
REQ-032 Reset, then 3 game_ticks -> dir=11 and 3 dir_valid pulses, each one CLK after its tick.
REQ-033 Bytes 1D, F0, 1D, then game_tick -> dir=00 and q_count returns to 0; the F0 1D release pair does not enqueue.
REQ-034 With dir=11, bytes E0 6B -> dropped as a reversal (q_count=0); then 1D followed by 1C -> q_count=2, and two ticks give dir=00 then dir=10.
REQ-035 With the queue full (QDEPTH=2), a 23 byte arriving in the same cycle as game_tick -> q_count stays 2 and the tail is RIGHT if it is not a reversal or duplicate.
REQ-036 Byte 29, then 4 ticks -> no dir_valid; 1B while paused is dropped; a second 29 resumes.
REQ-037 Assert game_over with q_count=2 and paused=1 -> next edge q_count=0, dir=11, paused=0; assert rstn=0 after byte E0 -> parser IDLE, and a following 75 is ignored.
